// File: rtl/timer_mc.sv
// Multi-channel count-up timer on the peripheral ICB bus: per-channel prescaler,
// one-shot/periodic expiry, sticky pending flags and a combined interrupt line.
module timer_mc #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PS_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icb_wr,
    input  logic [9:0]        icb_wadr,
    input  logic [31:0]       icb_wdat,
    output logic              icb_wack,
    input  logic              icb_rd,
    input  logic [9:0]        icb_radr,
    output logic [31:0]       icb_rdat,
    output logic              icb_rack,
    output logic [NUM_CH-1:0] int_vec_o,
    output logic              int_sig_o
);

    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] int_en;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] mode;
    logic [CNT_W-1:0]  count    [NUM_CH];
    logic [CNT_W-1:0]  value    [NUM_CH];
    logic [PS_W-1:0]   prescale [NUM_CH];
    logic [PS_W-1:0]   ps_cnt   [NUM_CH];

    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] ctrl_wr;
    logic [NUM_CH-1:0] value_wr;
    logic [NUM_CH-1:0] ps_wr;
    logic              status_wr;
    logic              unused_bits;

    assign icb_wack    = icb_wr;
    assign icb_rack    = icb_rd;
    assign status_wr   = icb_wr && (icb_wadr[9:2] == 8'hFC);
    assign int_vec_o   = pending & int_en;
    assign int_sig_o   = |int_vec_o;
    assign unused_bits = ^{icb_wadr[1:0], icb_radr[1:0], icb_wdat};

    // The STATUS address decodes to channel 63, so it never aliases a real channel.
    always_comb begin
        tick     = '0;
        expire   = '0;
        ctrl_wr  = '0;
        value_wr = '0;
        ps_wr    = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            tick[n]     = enable[n] && (ps_cnt[n] == prescale[n]);
            expire[n]   = tick[n] && (count[n] >= value[n]);
            ctrl_wr[n]  = icb_wr && (icb_wadr[9:4] == 6'(n)) && (icb_wadr[3:2] == 2'd0);
            value_wr[n] = icb_wr && (icb_wadr[9:4] == 6'(n)) && (icb_wadr[3:2] == 2'd2);
            ps_wr[n]    = icb_wr && (icb_wadr[9:4] == 6'(n)) && (icb_wadr[3:2] == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable  <= '0;
            int_en  <= '0;
            pending <= '0;
            mode    <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                count[n]    <= '0;
                value[n]    <= '0;
                prescale[n] <= '0;
                ps_cnt[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (!enable[n]) begin
                    ps_cnt[n] <= '0;
                    count[n]  <= '0;
                end else if (tick[n]) begin
                    ps_cnt[n] <= '0;
                    count[n]  <= expire[n] ? '0 : count[n] + CNT_W'(1);
                end else begin
                    ps_cnt[n] <= ps_cnt[n] + PS_W'(1);
                end

                if (expire[n] && !mode[n])
                    enable[n] <= 1'b0;

                // A software write overrides the one-shot self-disable in the same cycle.
                if (ctrl_wr[n]) begin
                    enable[n] <= icb_wdat[0];
                    int_en[n] <= icb_wdat[1];
                    mode[n]   <= icb_wdat[3];
                    if (!icb_wdat[0]) begin
                        count[n]  <= '0;
                        ps_cnt[n] <= '0;
                    end
                end

                if (value_wr[n])
                    value[n] <= icb_wdat[CNT_W-1:0];
                if (ps_wr[n])
                    prescale[n] <= icb_wdat[PS_W-1:0];

                if (expire[n])
                    pending[n] <= 1'b1;
                else if ((ctrl_wr[n] && icb_wdat[2]) || (status_wr && icb_wdat[n]))
                    pending[n] <= 1'b0;
            end
        end
    end

    always_comb begin
        icb_rdat = '0;
        if (!rst) begin
            if (icb_radr[9:2] == 8'hFC)
                icb_rdat[NUM_CH-1:0] = pending;
            for (int n = 0; n < NUM_CH; n++) begin
                if (icb_radr[9:4] == 6'(n)) begin
                    case (icb_radr[3:2])
                        2'd0: icb_rdat[3:0]       = {mode[n], pending[n], int_en[n], enable[n]};
                        2'd1: icb_rdat[CNT_W-1:0] = count[n];
                        2'd2: icb_rdat[CNT_W-1:0] = value[n];
                        2'd3: icb_rdat[PS_W-1:0]  = prescale[n];
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_mc.sv
// Directed self-checking bench for timer_mc, built with CNT_W=8 so the counter wrap is reachable.
module tb_timer_mc;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int PS_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              icb_wr = 1'b0;
    logic [9:0]        icb_wadr = '0;
    logic [31:0]       icb_wdat = '0;
    logic              icb_wack;
    logic              icb_rd = 1'b0;
    logic [9:0]        icb_radr = '0;
    logic [31:0]       icb_rdat;
    logic              icb_rack;
    logic [NUM_CH-1:0] int_vec_o;
    logic              int_sig_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] rd;

    timer_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PS_W(PS_W)) dut (
        .clk(clk), .rst(rst),
        .icb_wr(icb_wr), .icb_wadr(icb_wadr), .icb_wdat(icb_wdat), .icb_wack(icb_wack),
        .icb_rd(icb_rd), .icb_radr(icb_radr), .icb_rdat(icb_rdat), .icb_rack(icb_rack),
        .int_vec_o(int_vec_o), .int_sig_o(int_sig_o)
    );

    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Write lands on the next rising edge; returns 1 time unit after that edge.
    task automatic applyStimulus(input logic [9:0] addr, input logic [31:0] data);
        @(negedge clk);
        icb_wr   = 1'b1;
        icb_wadr = addr;
        icb_wdat = data;
        @(posedge clk);
        #1;
        icb_wr = 1'b0;
    endtask

    task automatic readReg(input logic [9:0] addr, output logic [31:0] data);
        icb_rd   = 1'b1;
        icb_radr = addr;
        #1;
        data   = icb_rdat;
        icb_rd = 1'b0;
    endtask

    task automatic checkReg(input string tag, input logic [9:0] addr, input logic [31:0] expected);
        logic [31:0] d;
        readReg(addr, d);
        checkOutput(tag, d, expected);
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stepCycles(1);
    endtask

    initial begin
        $display("[TB] timer_mc directed test start");
        stepCycles(2);
        checkReg("rdat_in_reset", 10'h008, 32'h0);
        checkOutput("int_vec_reset", 32'(int_vec_o), 32'h0);
        checkOutput("int_sig_reset", 32'(int_sig_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        stepCycles(1);
        checkReg("ctrl0_reset", 10'h000, 32'h0);
        checkReg("count0_reset", 10'h004, 32'h0);
        checkReg("ps3_reset", 10'h03C, 32'h0);
        checkReg("status_reset", 10'h3F0, 32'h0);

        // Zero-wait acks and read-old-on-same-cycle-write
        @(negedge clk);
        icb_wr = 1'b1; icb_wadr = 10'h018; icb_wdat = 32'd9;
        icb_rd = 1'b1; icb_radr = 10'h018;
        #1;
        checkOutput("wack", 32'(icb_wack), 32'h1);
        checkOutput("rack", 32'(icb_rack), 32'h1);
        checkOutput("rd_old_on_write", icb_rdat, 32'h0);
        @(posedge clk);
        #1;
        icb_wr = 1'b0; icb_rd = 1'b0;
        checkReg("rd_new_after_write", 10'h018, 32'd9);

        // One-shot on ch0
        applyStimulus(10'h008, 32'd5);
        applyStimulus(10'h00C, 32'd0);
        applyStimulus(10'h000, 32'h3);
        stepCycles(3);
        checkReg("os_count3", 10'h004, 32'd3);
        stepCycles(2);
        checkOutput("os_sig_early", 32'(int_sig_o), 32'h0);
        stepCycles(1);
        checkOutput("os_sig", 32'(int_sig_o), 32'h1);
        checkOutput("os_vec", 32'(int_vec_o), 32'h1);
        checkReg("os_ctrl", 10'h000, 32'h6);
        checkReg("os_count0", 10'h004, 32'h0);
        stepCycles(2);
        checkReg("os_stopped", 10'h004, 32'h0);
        applyStimulus(10'h000, 32'h4);
        checkReg("os_ctrl_clr", 10'h000, 32'h0);
        checkOutput("os_sig_clr", 32'(int_sig_o), 32'h0);

        // Periodic with prescaler on ch2
        applyStimulus(10'h028, 32'd3);
        applyStimulus(10'h02C, 32'd2);
        applyStimulus(10'h020, 32'hB);
        stepCycles(2);
        checkReg("per_count_t2", 10'h024, 32'd0);
        checkOutput("per_vec_t2", 32'(int_vec_o), 32'h0);
        stepCycles(1);
        checkReg("per_count_t3", 10'h024, 32'd1);
        stepCycles(3);
        checkReg("per_count_t6", 10'h024, 32'd2);
        stepCycles(3);
        checkReg("per_count_t9", 10'h024, 32'd3);
        stepCycles(2);
        checkOutput("per_vec_t11", 32'(int_vec_o), 32'h0);
        stepCycles(1);
        checkOutput("per_vec_t12", 32'(int_vec_o), 32'h4);
        checkReg("per_count_t12", 10'h024, 32'd0);
        checkReg("per_ctrl_t12", 10'h020, 32'hF);
        checkReg("per_status_t12", 10'h3F0, 32'h4);
        applyStimulus(10'h3F0, 32'h4);
        checkOutput("per_vec_t13", 32'(int_vec_o), 32'h0);
        stepCycles(10);
        checkOutput("per_vec_t23", 32'(int_vec_o), 32'h0);
        stepCycles(1);
        checkOutput("per_vec_t24", 32'(int_vec_o), 32'h4);
        applyStimulus(10'h3F0, 32'h4);
        checkOutput("per_vec_t25", 32'(int_vec_o), 32'h0);
        stepCycles(10);
        checkOutput("per_vec_t35", 32'(int_vec_o), 32'h0);
        stepCycles(1);
        checkOutput("per_vec_t36", 32'(int_vec_o), 32'h4);

        // Clear lands on the t+48 expiry edge, then a clear one cycle later
        stepCycles(11);
        applyStimulus(10'h020, 32'hF);
        checkOutput("coll_sig", 32'(int_sig_o), 32'h1);
        checkReg("coll_ctrl", 10'h020, 32'hF);
        applyStimulus(10'h020, 32'hF);
        checkOutput("coll_sig_drop", 32'(int_sig_o), 32'h0);
        checkReg("coll_ctrl_after", 10'h020, 32'hB);

        // Isolation: four periodic channels with periods 2,3,4,5
        doReset();
        for (int n = 0; n < NUM_CH; n++)
            applyStimulus(10'(n * 16 + 8), 32'(n + 1));
        for (int n = 0; n < NUM_CH; n++)
            applyStimulus(10'(n * 16), 32'hB);
        checkOutput("iso_vec_e3", 32'(int_vec_o), 32'h1);
        stepCycles(1);
        checkOutput("iso_vec_e4", 32'(int_vec_o), 32'h3);
        stepCycles(2);
        checkOutput("iso_vec_e6", 32'(int_vec_o), 32'h7);
        stepCycles(1);
        checkOutput("iso_vec_e7", 32'(int_vec_o), 32'h7);
        stepCycles(1);
        checkOutput("iso_vec_e8", 32'(int_vec_o), 32'hF);
        checkReg("iso_cnt0", 10'h004, 32'd0);
        checkReg("iso_cnt1", 10'h014, 32'd1);
        checkReg("iso_cnt2", 10'h024, 32'd2);
        checkReg("iso_cnt3", 10'h034, 32'd0);
        applyStimulus(10'h3F0, 32'hF);
        checkOutput("iso_vec_e9", 32'(int_vec_o), 32'h0);
        stepCycles(1);
        checkOutput("iso_vec_e10", 32'(int_vec_o), 32'h7);
        stepCycles(3);
        checkOutput("iso_vec_e13", 32'(int_vec_o), 32'hF);

        // Unmapped channel and addresses
        checkReg("map_ch4_ctrl", 10'h040, 32'h0);
        checkReg("map_ch4_value", 10'h048, 32'h0);
        checkReg("map_3f4", 10'h3F4, 32'h0);
        applyStimulus(10'h048, 32'h77);
        applyStimulus(10'h040, 32'h0);
        checkReg("map_ch4_value_wr", 10'h048, 32'h0);
        checkReg("map_ch0_value", 10'h008, 32'h1);
        readReg(10'h000, rd);
        checkOutput("map_ch0_ctrl", rd & 32'hB, 32'hB);

        // VALUE=0 expires every tick (ch1, PRESCALE=1)
        doReset();
        applyStimulus(10'h01C, 32'd1);
        applyStimulus(10'h010, 32'hB);
        stepCycles(1);
        checkOutput("v0_vec_t1", 32'(int_vec_o), 32'h0);
        stepCycles(1);
        checkOutput("v0_vec_t2", 32'(int_vec_o), 32'h2);
        checkReg("v0_count", 10'h014, 32'h0);
        applyStimulus(10'h3F0, 32'h2);
        checkOutput("v0_vec_t3", 32'(int_vec_o), 32'h0);
        stepCycles(1);
        checkOutput("v0_vec_t4", 32'(int_vec_o), 32'h2);
        applyStimulus(10'h010, 32'h4);
        checkOutput("v0_vec_off", 32'(int_vec_o), 32'h0);

        // Enable write on the one-shot expiry edge restarts the channel
        applyStimulus(10'h008, 32'd2);
        applyStimulus(10'h000, 32'h3);
        stepCycles(2);
        applyStimulus(10'h000, 32'h3);
        checkReg("rst_ctrl_t3", 10'h000, 32'h7);
        checkReg("rst_count_t3", 10'h004, 32'h0);
        stepCycles(2);
        checkReg("rst_count_t5", 10'h004, 32'd2);
        stepCycles(1);
        checkReg("rst_ctrl_t6", 10'h000, 32'h6);
        applyStimulus(10'h000, 32'h4);

        // VALUE written below COUNT expires on the next tick
        applyStimulus(10'h008, 32'd20);
        applyStimulus(10'h00C, 32'd3);
        applyStimulus(10'h000, 32'h3);
        stepCycles(28);
        checkReg("low_count_t28", 10'h004, 32'd7);
        applyStimulus(10'h008, 32'd2);
        stepCycles(2);
        checkOutput("low_vec_t31", 32'(int_vec_o), 32'h0);
        checkReg("low_count_t31", 10'h004, 32'd7);
        stepCycles(1);
        checkOutput("low_vec_t32", 32'(int_vec_o), 32'h1);
        checkReg("low_count_t32", 10'h004, 32'd0);
        checkReg("low_ctrl_t32", 10'h000, 32'h6);
        applyStimulus(10'h000, 32'h4);

        // 8-bit counter wrap on ch3
        applyStimulus(10'h038, 32'h1FF);
        checkReg("wrap_value", 10'h038, 32'hFF);
        applyStimulus(10'h030, 32'hB);
        stepCycles(255);
        checkReg("wrap_count_255", 10'h034, 32'hFF);
        checkOutput("wrap_vec_255", 32'(int_vec_o), 32'h0);
        stepCycles(1);
        checkOutput("wrap_vec_256", 32'(int_vec_o), 32'h8);
        checkReg("wrap_count_256", 10'h034, 32'h0);

        // Reset while counting
        applyStimulus(10'h028, 32'd100);
        applyStimulus(10'h020, 32'h3);
        @(negedge clk);
        rst = 1'b1;
        checkReg("mid_rdat_in_rst", 10'h038, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("mid_vec", 32'(int_vec_o), 32'h0);
        checkOutput("mid_sig", 32'(int_sig_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        stepCycles(1);
        checkReg("mid_ctrl3", 10'h030, 32'h0);
        checkReg("mid_count3", 10'h034, 32'h0);
        checkReg("mid_value3", 10'h038, 32'h0);
        checkReg("mid_ctrl2", 10'h020, 32'h0);
        checkReg("mid_value2", 10'h028, 32'h0);
        checkReg("mid_status", 10'h3F0, 32'h0);
        stepCycles(5);
        checkReg("mid_count3_idle", 10'h034, 32'h0);
        checkOutput("mid_sig_idle", 32'(int_sig_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
